swap_unit_arbiter: RTL and testbench

//   Shares one two-register exchange datapath (regs A/B) between NREQ requesters.

---
 rtl/swap_unit_arbiter_if.sv | 20 ++
 rtl/swap_unit_arbiter.sv | 97 +++++++++
 tb/tb_swap_unit_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/swap_unit_arbiter_if.sv
// swap_unit_arbiter_if: requester-side bundle of the shared swap datapath
interface swap_unit_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int W     = 8,
  parameter int CNT_W = 4
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0]       req;
  logic [NREQ*W-1:0]     op_a;
  logic [NREQ*W-1:0]     op_b;
  logic [NREQ*CNT_W-1:0] n_swaps;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  done;
  logic [IW-1:0]         done_id;
  logic [W-1:0]          res_a;
  logic [W-1:0]          res_b;
  modport master (output req, op_a, op_b, n_swaps, input grant, busy, done, done_id, res_a, res_b);
  modport slave  (input req, op_a, op_b, n_swaps, output grant, busy, done, done_id, res_a, res_b);
endinterface

// File: rtl/swap_unit_arbiter.sv
// swap_unit_arbiter: round-robin scheduler for a shared A/B exchange register pair
module swap_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              rst,
  swap_unit_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWAP, S_DONE} state_t;
  state_t           r_state;
  logic [IW-1:0]    r_ptr, r_id, r_done_id, w_sel, w_nxt_ptr;
  logic             w_found, r_busy, r_done;
  logic [NREQ-1:0]  r_grant;
  logic [W-1:0]     r_a, r_b, r_res_a, r_res_b, w_op_a, w_op_b;
  logic [CNT_W-1:0] r_cnt, w_n;
  // first set request at or after the pointer, wrapping; low k wins by being assigned last
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_sel   = IW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end
  assign w_nxt_ptr = (w_sel == IW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
  assign w_op_a    = bus.op_a[r_id*W +: W];
  assign w_op_b    = bus.op_b[r_id*W +: W];
  assign w_n       = bus.n_swaps[r_id*CNT_W +: CNT_W];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_res_a   <= '0;
      r_res_b   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          r_state <= S_LOAD;
          r_grant <= NREQ'(1) << w_sel;
          r_busy  <= 1'b1;
          r_id    <= w_sel;
          r_ptr   <= w_nxt_ptr;
        end
        S_LOAD: begin
          r_a   <= w_op_a;
          r_b   <= w_op_b;
          r_cnt <= w_n;
          r_state <= (w_n == '0) ? S_DONE : S_SWAP;
          if (w_n == '0) begin
            r_done    <= 1'b1;
            r_done_id <= r_id;
            r_res_a   <= w_op_a;
            r_res_b   <= w_op_b;
          end
        end
        S_SWAP: begin
          r_a   <= r_b;
          r_b   <= r_a;
          r_cnt <= r_cnt - 1'b1;
          // result is captured from the post-swap values of the final exchange
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_done_id <= r_id;
            r_res_a   <= r_b;
            r_res_b   <= r_a;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.grant   = r_grant;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.res_a   = r_res_a;
  assign bus.res_b   = r_res_b;
endmodule

// File: tb/tb_swap_unit_arbiter.sv
// tb_swap_unit_arbiter: directed checks of arbitration order, latency, results and reset abort
module tb_swap_unit_arbiter;
  localparam int NREQ = 4, W = 8, CNT_W = 4;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0, errors = 0;
  int   c, seen;
  always #5 clk = ~clk;
  swap_unit_arbiter_if #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W)) bus ();
  swap_unit_arbiter #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_job(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [CNT_W-1:0] n);
    bus.op_a[i*W +: W]          = a;
    bus.op_b[i*W +: W]          = b;
    bus.n_swaps[i*CNT_W +: CNT_W] = n;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.done && cyc < 40);
  endtask
  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.n_swaps = '0;
    tick();
    tick();
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_res_a", bus.res_a, 0);
    check("rst_res_b", bus.res_b, 0);
    rst = 1'b0;
    set_job(0, 8'h12, 8'h34, 4'd1);
    bus.req = 4'b0001;
    tick();
    check("t2_grant_c1", bus.grant, 4'b0001);
    check("t2_busy_c1", bus.busy, 1);
    check("t2_done_c1", bus.done, 0);
    bus.req = '0;
    tick();
    check("t2_grant_c2", bus.grant, 4'b0001);
    check("t2_done_c2", bus.done, 0);
    tick();
    check("t2_grant_c3", bus.grant, 4'b0001);
    check("t2_done_c3", bus.done, 1);
    check("t2_id", bus.done_id, 0);
    check("t2_res_a", bus.res_a, 8'h34);
    check("t2_res_b", bus.res_b, 8'h12);
    tick();
    check("t2_done_c4", bus.done, 0);
    check("t2_grant_c4", bus.grant, 0);
    check("t2_busy_c4", bus.busy, 0);
    check("t2_res_hold", bus.res_a, 8'h34);
    set_job(1, 8'hA5, 8'h5A, 4'd0);
    bus.req = 4'b0010;
    wait_done(c);
    check("t3_n0_lat", c, 2);
    check("t3_n0_id", bus.done_id, 1);
    check("t3_n0_res_a", bus.res_a, 8'hA5);
    check("t3_n0_res_b", bus.res_b, 8'h5A);
    set_job(1, 8'hC3, 8'h3C, 4'd2);
    wait_done(c);
    bus.req = '0;
    check("t3_n2_lat", c, 5);
    check("t3_n2_id", bus.done_id, 1);
    check("t3_n2_res_a", bus.res_a, 8'hC3);
    check("t3_n2_res_b", bus.res_b, 8'h3C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NREQ; k++) set_job(k, 8'(8'h10 + k), 8'(8'h80 + k), 4'd1);
    bus.req = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      wait_done(c);
      check($sformatf("t4_lat%0d", k), c, (k == 0) ? 3 : 4);
      check($sformatf("t4_id%0d", k), bus.done_id, k);
      check($sformatf("t4_grant%0d", k), bus.grant, 1 << k);
      check($sformatf("t4_res_a%0d", k), bus.res_a, 8'h80 + k);
      check($sformatf("t4_res_b%0d", k), bus.res_b, 8'h10 + k);
    end
    bus.req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_done(c);
      check($sformatf("t5_lat%0d", k), c, 4);
      check($sformatf("t5_id%0d", k), bus.done_id, (k % 2 == 0) ? 0 : 2);
    end
    set_job(1, 8'h77, 8'h99, 4'd5);
    bus.req = 4'b0010;
    for (int k = 0; k < 4; k++) tick();
    check("t6_busy_swap", bus.busy, 1);
    check("t6_grant_swap", bus.grant, 4'b0010);
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
    check("t6_busy", bus.busy, 0);
    check("t6_grant", bus.grant, 0);
    check("t6_done", bus.done, 0);
    check("t6_res_a", bus.res_a, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done) seen = 1;
    end
    check("t6_no_done", seen, 0);
    bus.req = 4'b0101;
    tick();
    check("t6_ptr_restart", bus.grant, 4'b0001);
    bus.req = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
